// File: rtl/change_dispenser.sv
// Change dispenser: pays a 5-bit change amount as 10/5/2/1 coins,
// greedy over a finite refillable inventory, one eject pulse per coin.
module change_dispenser #(
  parameter int INV_W      = 4,
  parameter int INV_INIT   = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       change,
  input  logic             refill,
  output logic [3:0]       dispense,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [4:0]       remaining,
  output logic [INV_W-1:0] inv10,
  output logic [INV_W-1:0] inv5,
  output logic [INV_W-1:0] inv2,
  output logic [INV_W-1:0] inv1
);

  localparam int GW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST =
    (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [INV_W-1:0] INIT = INV_W'(INV_INIT);
  localparam logic [INV_W-1:0] ONE  = INV_W'(1);
  localparam logic [GW-1:0]    GLD  = GW'(GAP_LAST);

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    EJECT,
    GAP,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [4:0]       rem_n;
  logic             short_n;
  logic [3:0]       sel;
  logic [3:0]       sel_n;
  logic [GW-1:0]    gap_cnt;
  logic [GW-1:0]    gap_n;
  logic [INV_W-1:0] i10_n;
  logic [INV_W-1:0] i5_n;
  logic [INV_W-1:0] i2_n;
  logic [INV_W-1:0] i1_n;
  logic             can10;
  logic             can5;
  logic             can2;
  logic             can1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      short     <= 1'b0;
      sel       <= '0;
      gap_cnt   <= '0;
      inv10     <= INIT;
      inv5      <= INIT;
      inv2      <= INIT;
      inv1      <= INIT;
    end else begin
      state     <= state_n;
      remaining <= rem_n;
      short     <= short_n;
      sel       <= sel_n;
      gap_cnt   <= gap_n;
      inv10     <= i10_n;
      inv5      <= i5_n;
      inv2      <= i2_n;
      inv1      <= i1_n;
    end
  end

  // A coin is eligible only if it fits and is in stock.
  always_comb begin
    can10 = (remaining >= 5'd10) && (inv10 != '0);
    can5  = (remaining >= 5'd5)  && (inv5  != '0);
    can2  = (remaining >= 5'd2)  && (inv2  != '0);
    can1  = (remaining >= 5'd1)  && (inv1  != '0);
  end

  always_comb begin
    state_n  = state;
    rem_n    = remaining;
    short_n  = short;
    sel_n    = sel;
    gap_n    = gap_cnt;
    i10_n    = inv10;
    i5_n     = inv5;
    i2_n     = inv2;
    i1_n     = inv1;
    dispense = '0;
    busy     = (state != IDLE);
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (refill) begin
          i10_n = INIT;
          i5_n  = INIT;
          i2_n  = INIT;
          i1_n  = INIT;
        end
        if (start) begin
          rem_n   = change;
          short_n = 1'b0;
          state_n = PICK;
        end
      end
      PICK: begin
        state_n = EJECT;
        case (1'b1)
          (remaining == 5'd0): begin
            state_n = DONE;
            short_n = 1'b0;
          end
          can10: begin
            sel_n = 4'b1000;
            i10_n = inv10 - ONE;
            rem_n = remaining - 5'd10;
          end
          can5: begin
            sel_n = 4'b0100;
            i5_n  = inv5 - ONE;
            rem_n = remaining - 5'd5;
          end
          can2: begin
            sel_n = 4'b0010;
            i2_n  = inv2 - ONE;
            rem_n = remaining - 5'd2;
          end
          can1: begin
            sel_n = 4'b0001;
            i1_n  = inv1 - ONE;
            rem_n = remaining - 5'd1;
          end
          default: begin
            state_n = DONE;
            short_n = 1'b1;
          end
        endcase
      end
      EJECT: begin
        dispense = sel;
        if (GAP_CYCLES > 0) begin
          state_n = GAP;
          gap_n   = GLD;
        end else begin
          state_n = PICK;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_n = PICK;
        end else begin
          gap_n = gap_cnt - GW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: coin order, pulse timing,
// shortfall, ignored inputs and mid-job reset.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] change;
  logic       refill;
  logic [3:0] dispense;
  logic       busy;
  logic       done;
  logic       short;
  logic [4:0] remaining;
  logic [3:0] inv10;
  logic [3:0] inv5;
  logic [3:0] inv2;
  logic [3:0] inv1;

  int checks = 0;
  int errors = 0;

  logic [3:0] pq[$];
  int         cq[$];
  int         done_cyc;
  int         busy_cnt;
  logic       d_short;
  logic [4:0] d_rem;

  change_dispenser #(
    .INV_W(4),
    .INV_INIT(3),
    .GAP_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .change(change),
    .refill(refill),
    .dispense(dispense),
    .busy(busy),
    .done(done),
    .short(short),
    .remaining(remaining),
    .inv10(inv10),
    .inv5(inv5),
    .inv2(inv2),
    .inv1(inv1)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    refill = 1'b0;
    change = 5'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_refill();
    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
  endtask

  // Runs one job; cycle k is the k-th cycle after the start edge.
  task automatic run_job(input logic [4:0] ch, input bit poke);
    pq.delete();
    cq.delete();
    done_cyc = -1;
    busy_cnt = 0;
    d_short  = 1'bx;
    d_rem    = 5'bx;
    @(negedge clk);
    start  = 1'b1;
    change = ch;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (poke && k == 3) begin
        start  = 1'b1;
        change = 5'd7;
        refill = 1'b1;
      end else if (poke && k == 4) begin
        start  = 1'b0;
        refill = 1'b0;
      end
      if (busy) busy_cnt++;
      if (dispense != 4'b0) begin
        pq.push_back(dispense);
        cq.push_back(k);
      end
      if (done) begin
        done_cyc = k;
        d_short  = short;
        d_rem    = remaining;
        break;
      end
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL job_timeout got no done want done");
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, done, short, dispense} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 0",
               {busy, done, short, dispense});
    end
    checks++;
    if (remaining !== 5'd0) begin
      errors++;
      $display("FAIL reset_rem got %0d want 0", remaining);
    end
    checks++;
    if ({inv10, inv5, inv2, inv1} !== 16'h3333) begin
      errors++;
      $display("FAIL reset_inv got %h want 3333",
               {inv10, inv5, inv2, inv1});
    end
  endtask

  task automatic test_change18();
    logic [3:0] exp [4];
    exp = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    run_job(5'd18, 1'b0);
    checks++;
    if (pq.size() != 4) begin
      errors++;
      $display("FAIL c18_count got %0d want 4", pq.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= pq.size() || pq[i] !== exp[i]
          || cq[i] != 2 + 4 * i) begin
        errors++;
        $display("FAIL c18_pulse%0d got %b@%0d want %b@%0d", i,
                 (i < pq.size()) ? pq[i] : 4'bx,
                 (i < cq.size()) ? cq[i] : -1,
                 exp[i], 2 + 4 * i);
      end
    end
    checks++;
    if (done_cyc != 18 || d_short !== 1'b0 || d_rem !== 5'd0) begin
      errors++;
      $display("FAIL c18_done got cyc%0d s%b r%0d want cyc18 s0 r0",
               done_cyc, d_short, d_rem);
    end
    checks++;
    if ({inv10, inv5, inv2, inv1} !== 16'h2222) begin
      errors++;
      $display("FAIL c18_inv got %h want 2222",
               {inv10, inv5, inv2, inv1});
    end
  endtask

  task automatic test_change31_twice();
    logic [3:0] e1 [4];
    logic [3:0] e2 [8];
    e1 = '{4'b1000, 4'b1000, 4'b1000, 4'b0001};
    e2 = '{4'b0100, 4'b0100, 4'b0100, 4'b0010,
           4'b0010, 4'b0010, 4'b0001, 4'b0001};
    do_reset();
    run_job(5'd31, 1'b0);
    checks++;
    if (pq.size() != 4) begin
      errors++;
      $display("FAIL c31a_count got %0d want 4", pq.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= pq.size() || pq[i] !== e1[i]) begin
        errors++;
        $display("FAIL c31a_pulse%0d got %b want %b", i,
                 (i < pq.size()) ? pq[i] : 4'bx, e1[i]);
      end
    end
    checks++;
    if (d_short !== 1'b0 || d_rem !== 5'd0
        || {inv10, inv5, inv2, inv1} !== 16'h0332) begin
      errors++;
      $display("FAIL c31a_end got s%b r%0d inv%h want s0 r0 inv0332",
               d_short, d_rem, {inv10, inv5, inv2, inv1});
    end
    run_job(5'd31, 1'b0);
    checks++;
    if (pq.size() != 8) begin
      errors++;
      $display("FAIL c31b_count got %0d want 8", pq.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= pq.size() || pq[i] !== e2[i]) begin
        errors++;
        $display("FAIL c31b_pulse%0d got %b want %b", i,
                 (i < pq.size()) ? pq[i] : 4'bx, e2[i]);
      end
    end
    checks++;
    if (d_short !== 1'b1 || d_rem !== 5'd8
        || {inv10, inv5, inv2, inv1} !== 16'h0000) begin
      errors++;
      $display("FAIL c31b_end got s%b r%0d inv%h want s1 r8 inv0000",
               d_short, d_rem, {inv10, inv5, inv2, inv1});
    end
  endtask

  task automatic test_zero();
    run_job(5'd0, 1'b0);
    checks++;
    if (pq.size() != 0 || done_cyc != 2 || busy_cnt != 2) begin
      errors++;
      $display("FAIL zero_job got p%0d cyc%0d busy%0d want 0 2 2",
               pq.size(), done_cyc, busy_cnt);
    end
    checks++;
    if (d_short !== 1'b0 || d_rem !== 5'd0) begin
      errors++;
      $display("FAIL zero_flags got s%b r%0d want s0 r0",
               d_short, d_rem);
    end
  endtask

  task automatic test_greedy();
    do_refill();
    for (int j = 0; j < 3; j++) run_job(5'd1, 1'b0);
    checks++;
    if ({inv10, inv5, inv2, inv1} !== 16'h3330) begin
      errors++;
      $display("FAIL greedy_pre got %h want 3330",
               {inv10, inv5, inv2, inv1});
    end
    run_job(5'd6, 1'b0);
    checks++;
    if (pq.size() != 1 || (pq.size() > 0 && pq[0] !== 4'b0100)) begin
      errors++;
      $display("FAIL greedy_pulses got n%0d want one 0100",
               pq.size());
    end
    checks++;
    if (d_short !== 1'b1 || d_rem !== 5'd1) begin
      errors++;
      $display("FAIL greedy_short got s%b r%0d want s1 r1",
               d_short, d_rem);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || remaining !== 5'd1 || short !== 1'b1) begin
      errors++;
      $display("FAIL greedy_hold got b%b r%0d s%b want b0 r1 s1",
               busy, remaining, short);
    end
  endtask

  task automatic test_ignored_inputs();
    logic [3:0] exp [4];
    exp = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    do_refill();
    run_job(5'd18, 1'b1);
    checks++;
    if (pq.size() != 4 || done_cyc != 18) begin
      errors++;
      $display("FAIL ign_count got n%0d cyc%0d want n4 cyc18",
               pq.size(), done_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= pq.size() || pq[i] !== exp[i]) begin
        errors++;
        $display("FAIL ign_pulse%0d got %b want %b", i,
                 (i < pq.size()) ? pq[i] : 4'bx, exp[i]);
      end
    end
    checks++;
    if ({inv10, inv5, inv2, inv1} !== 16'h2222 || d_rem !== 5'd0) begin
      errors++;
      $display("FAIL ign_inv got %h r%0d want 2222 r0",
               {inv10, inv5, inv2, inv1}, d_rem);
    end
    do_refill();
    checks++;
    if ({inv10, inv5, inv2, inv1} !== 16'h3333) begin
      errors++;
      $display("FAIL refill_inv got %h want 3333",
               {inv10, inv5, inv2, inv1});
    end
  endtask

  task automatic test_mid_reset();
    int dn;
    dn = 0;
    @(negedge clk);
    start  = 1'b1;
    change = 5'd18;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (dispense !== 4'b1000) begin
      errors++;
      $display("FAIL mrst_eject got %b want 1000", dispense);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busy, done, dispense} !== 6'b0 || remaining !== 5'd0) begin
      errors++;
      $display("FAIL mrst_state got %b r%0d want 0 r0",
               {busy, done, dispense}, remaining);
    end
    checks++;
    if ({inv10, inv5, inv2, inv1} !== 16'h3333) begin
      errors++;
      $display("FAIL mrst_inv got %h want 3333",
               {inv10, inv5, inv2, inv1});
    end
    repeat (20) begin
      @(negedge clk);
      if (done || dispense != 4'b0) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL mrst_quiet got %0d want 0", dn);
    end
  endtask

  initial begin
    test_reset();
    test_change18();
    test_change31_twice();
    test_zero();
    test_greedy();
    test_ignored_inputs();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sits directly downstream of vending_machine and consumes its 5-bit change result.
- Ejects that change as physical coins, one coin per eject pulse, using greedy selection over a finite coin inventory (10, 5, 2, 1).
- Reports completion and the remaining shortfall to the controller.

Parameters:
- INV_W, 4: width of each per-denomination inventory counter.
- INV_INIT, 3: coins of each denomination loaded at reset and on refill; must be at most 2^INV_W-1.
- GAP_CYCLES, 2: idle cycles after each eject pulse (mechanism settle time); 0 is legal.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; samples change; honoured only in IDLE.
- change  in  5  amount to return, 0..31, from vending_machine.
- refill  in  1  reloads all inventories to INV_INIT; honoured only in IDLE.
- dispense  out  4  one-hot eject strobe: bit3=10, bit2=5, bit1=2, bit0=1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- short  out  1  valid with done: change could not be fully paid.
- remaining  out  5  unpaid amount; holds its value until the next accepted start.
- inv10, inv5, inv2, inv1  out  INV_W each  current inventory per denomination.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - dispense=0, done=0, short=0, remaining=0, gap counter=0.
  - All inventories=INV_INIT.
  - Reset has priority over every other input and aborts a job at any state. No done pulse is produced for the aborted job.
- States: IDLE, PICK, EJECT, GAP, DONE.
- IDLE:
  - start=1 → remaining<=change, short<=0, go to PICK.
  - If start=1 and refill=1 in the same cycle, the refill executes and the start is also accepted. The new inventory is visible to the first PICK.
  - If refill=1 alone, inventories<=INV_INIT and the state stays IDLE.
- PICK: select d = the largest of {10,5,2,1} with d<=remaining and inventory(d)>0.
  - If remaining=0 → DONE, short<=0.
  - If no d exists → DONE, short<=1.
  - Otherwise → EJECT; register the one-hot for d; inventory(d)-=1; remaining-=d.
- EJECT:
  - dispense = the registered one-hot, for exactly 1 cycle.
  - Next state is GAP if GAP_CYCLES>0, else PICK.
- GAP: dispense=0 for exactly GAP_CYCLES cycles, then PICK.
- DONE: done=1 for 1 cycle; short is held from PICK; then IDLE.
- dispense is zero in every state except EJECT and is always one-hot or zero.
- Timing:
  - Eject pulses are spaced GAP_CYCLES+2 cycles apart (rising edge to rising edge).
  - The first pulse is high in the 2nd cycle after the edge that sampled start.
  - A job with change=0 gives done in the 2nd cycle after start, with no pulses and short=0.
- Ignored inputs: start or refill while busy is ignored; it is not queued and has no effect on the job in progress.
- Greedy only, by design: the block does not backtrack. Example: change=6 with inv1=0, inv2>=3, inv5>=1 pays 5, then reports short with remaining=1. Bench checks must encode this.
- Inventories never underflow; a denomination at 0 is skipped.
- remaining is unsigned 5-bit and never wraps, because d<=remaining is enforced.

Test Plan:
- Reset, then start change=18, GAP_CYCLES=2:
  - dispense pulses 1000, 0100, 0010, 0001, each 1 cycle, 4 cycles apart.
  - Then done=1, short=0, remaining=0; inv10=2, inv5=2, inv2=2, inv1=2.
- Reset, start change=31: pulses 10,10,10,1; done, short=0; inv10=0, inv1=2.
- Then start change=31 again (no refill):
  - pulses 5,5,5,2,2,2,1,1.
  - done with short=1, remaining=8; all inventories 0.
- start change=0: no dispense pulses; done in the 2nd cycle after start; short=0, remaining=0, busy high for 2 cycles.
- Mid-job inputs: during a change=18 job, pulse start (change=7) and refill in GAP.
  - Both are ignored: original coin sequence and inventories are unchanged.
  - After done, refill restores all inventories to 3.
- Mid-job reset: start change=18, drive rst_n=0 at the first EJECT cycle.
  - Next cycle: IDLE, dispense=0, done never pulses, remaining=0, inventories=3.
